pattern_stream_writer: RTL and testbench



---
 rtl/pattern_stream_writer.sv | 170 +++++++++++++++++
 tb/tb_pattern_stream_writer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_stream_writer.sv
//----------------------------------------------------------------------------
// Module  : pattern_stream_writer
// Brief   : Fills a DEPTH-entry bit memory with an LFSR or repeated-pattern
//           stream and keeps a non-overlapping reference match count.
//           Optional macro FORCE_PATTERN_EN seeds LFSR fills with PATTERN.
// Rev     : 1.0
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module pattern_stream_writer #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter int                     DEPTH       = 16,
    parameter int                     ADDR_W      = 4
) (
    input  logic              clock_100Mhz,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [7:0]        seed,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic              dina,
    output logic              busy,
    output logic              done,
    output logic [7:0]        expected_count
);

    localparam int         c_CNT_W = ADDR_W + 1;
    localparam logic [7:0] c_PAT8  = 8'(PATTERN);
    localparam logic [2:0] c_LAST  = 3'(PATTERN_LEN - 1);
    localparam logic [3:0] c_GAPMX = 4'(PATTERN_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nx;
    logic [7:0]               r_lfsr;
    logic [2:0]               r_idx;
    logic                     r_mode;
    logic [c_CNT_W-1:0]       r_addr;
    logic [PATTERN_LEN-1:0]   r_window;
    logic [3:0]               r_gap;
    logic [7:0]               r_acc;

    logic                     w_write;
    logic                     w_done_nx;
    logic                     w_exp_ld;
    logic                     w_idle;
    logic [7:0]               w_src_lfsr;
    logic [2:0]               w_src_idx;
    logic                     w_src_mode;
    logic [c_CNT_W-1:0]       w_src_addr;
    logic [PATTERN_LEN-1:0]   w_src_window;
    logic [3:0]               w_src_gap;
    logic [7:0]               w_src_acc;
    logic                     w_bit;
    logic [7:0]               w_lfsr_nx;
    logic [2:0]               w_idx_nx;
    logic [PATTERN_LEN-1:0]   w_window_nx;
    logic                     w_match;
    logic [3:0]               w_gap_nx;
    logic [7:0]               w_acc_nx;

    // The first write is prepared on the start edge, so the stream sources
    // come from the inputs in IDLE and from the running state afterwards.
    assign w_idle       = (r_state == S_IDLE);
    assign w_src_lfsr   = w_idle ? ((seed == 8'h00) ? 8'h01 : seed) : r_lfsr;
    assign w_src_idx    = w_idle ? 3'd0 : r_idx;
    assign w_src_mode   = w_idle ? mode : r_mode;
    assign w_src_addr   = w_idle ? '0 : r_addr;
    assign w_src_window = w_idle ? '0 : r_window;
    assign w_src_gap    = w_idle ? 4'd0 : r_gap;
    assign w_src_acc    = w_idle ? 8'd0 : r_acc;

`ifdef FORCE_PATTERN_EN
    logic       w_in_prefix;
    logic [2:0] w_force_sel;
    assign w_in_prefix = (w_src_addr < c_CNT_W'(PATTERN_LEN));
    assign w_force_sel = c_LAST - w_src_addr[2:0];
    assign w_bit = w_src_mode  ? c_PAT8[c_LAST - w_src_idx] :
                   w_in_prefix ? c_PAT8[w_force_sel] : w_src_lfsr[7];
`else
    assign w_bit = w_src_mode ? c_PAT8[c_LAST - w_src_idx] : w_src_lfsr[7];
`endif

    assign w_lfsr_nx   = {w_src_lfsr[6:0],
                          w_src_lfsr[7] ^ w_src_lfsr[5] ^ w_src_lfsr[4] ^ w_src_lfsr[3]};
    assign w_idx_nx    = (w_src_idx == c_LAST) ? 3'd0 : w_src_idx + 3'd1;
    assign w_window_nx = {w_src_window[PATTERN_LEN-2:0], w_bit};

    // Non-overlapping: a match needs a full pattern length since the last one.
    assign w_match  = (w_window_nx == PATTERN) &&
                      (({1'b0, w_src_gap} + 5'd1) >= 5'(PATTERN_LEN));
    assign w_gap_nx = w_match ? 4'd0 :
                      (w_src_gap >= c_GAPMX) ? c_GAPMX : w_src_gap + 4'd1;
    assign w_acc_nx = (w_match && (w_src_acc != 8'hFF)) ? w_src_acc + 8'd1 : w_src_acc;

    always_comb begin
        w_state_nx = r_state;
        w_write    = 1'b0;
        w_done_nx  = 1'b0;
        w_exp_ld   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_write    = 1'b1;
                    w_state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_addr == c_CNT_W'(DEPTH)) begin
                    w_state_nx = S_DONE;
                    w_done_nx  = 1'b1;
                    w_exp_ld   = 1'b1;
                end else begin
                    w_write = 1'b1;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_lfsr         <= 8'h01;
            r_idx          <= 3'd0;
            r_mode         <= 1'b0;
            r_addr         <= '0;
            r_window       <= '0;
            r_gap          <= 4'd0;
            r_acc          <= 8'd0;
            wea            <= 1'b0;
            addra          <= '0;
            dina           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            expected_count <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            wea     <= w_write;
            busy    <= w_write;
            done    <= w_done_nx;
            if (w_exp_ld) begin
                expected_count <= r_acc;
            end
            if (w_write) begin
                addra    <= w_src_addr[ADDR_W-1:0];
                dina     <= w_bit;
                r_addr   <= w_src_addr + c_CNT_W'(1);
                r_lfsr   <= w_lfsr_nx;
                r_idx    <= w_idx_nx;
                r_mode   <= w_src_mode;
                r_window <= w_window_nx;
                r_gap    <= w_gap_nx;
                r_acc    <= w_acc_nx;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pattern_stream_writer.sv
//----------------------------------------------------------------------------
// Module  : tb_pattern_stream_writer
// Brief   : Self-checking bench for pattern_stream_writer (fill-level model).
// Rev     : 1.0
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pattern_stream_writer;

    localparam int         DEPTH  = 16;
    localparam int         PLEN   = 4;
    localparam int         ADDR_W = 4;
    localparam logic [3:0] PAT    = 4'b1011;
    localparam logic [3:0] PAT2   = 4'b1111;

    logic              clock_100Mhz = 1'b0;
    logic              reset        = 1'b1;
    logic              start        = 1'b0;
    logic              mode         = 1'b0;
    logic [7:0]        seed         = 8'h00;
    logic              wea, dina, busy, done;
    logic [ADDR_W-1:0] addra;
    logic [7:0]        expected_count;
    logic              b_wea, b_dina, b_busy, b_done;
    logic [ADDR_W-1:0] b_addra;
    logic [7:0]        b_expected_count;

    pattern_stream_writer #(.PATTERN_LEN(PLEN), .PATTERN(PAT), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock_100Mhz(clock_100Mhz), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .wea(wea), .addra(addra), .dina(dina), .busy(busy), .done(done),
        .expected_count(expected_count)
    );

    pattern_stream_writer #(.PATTERN_LEN(PLEN), .PATTERN(PAT2), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut2 (
        .clock_100Mhz(clock_100Mhz), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .wea(b_wea), .addra(b_addra), .dina(b_dina), .busy(b_busy), .done(b_done),
        .expected_count(b_expected_count)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Whole-fill reference: the bit written at each address, then the count.
    function automatic logic [DEPTH-1:0] gen_bits(input logic m, input logic [7:0] s);
        logic [DEPTH-1:0] b;
        logic [7:0]       l;
        logic [3:0]       p;
        p = PAT;
        l = (s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < DEPTH; i++) begin
            b[i] = m ? p[PLEN-1-(i % PLEN)] : l[7];
`ifdef FORCE_PATTERN_EN
            if (!m && i < PLEN) b[i] = p[PLEN-1-i];
`endif
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        return b;
    endfunction

    function automatic int ref_count(input logic [DEPTH-1:0] b);
        int         cnt;
        int         free_from;
        logic [3:0] w;
        cnt = 0;
        free_from = 0;
        for (int i = PLEN - 1; i < DEPTH; i++) begin
            for (int j = 0; j < PLEN; j++) w[PLEN-1-j] = b[i-PLEN+1+j];
            if (w == PAT && (i - PLEN + 1) >= free_from) begin
                cnt++;
                free_from = i + 1;
            end
        end
        return (cnt > 255) ? 255 : cnt;
    endfunction

    // m_k: 0 idle, 1..DEPTH = write cycle k (address k-1), DEPTH+1 = done cycle.
    int               m_k   = 0;
    int               m_cnt = 0;
    int               m_exp = 0;
    logic [DEPTH-1:0] m_bits = '0;
    logic             m_wr;
    logic             cmp_en = 1'b0;

    assign m_wr = (m_k >= 1) && (m_k <= DEPTH);

    always @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            m_k   <= 0;
            m_exp <= 0;
        end else if (m_k == 0) begin
            if (start) begin
                m_bits <= gen_bits(mode, seed);
                m_cnt  <= ref_count(gen_bits(mode, seed));
                m_k    <= 1;
            end
        end else if (m_k == DEPTH + 1) begin
            m_k <= 0;
        end else begin
            m_k <= m_k + 1;
            if (m_k == DEPTH) m_exp <= m_cnt;
        end
    end

    always @(negedge clock_100Mhz) begin
        if (cmp_en) begin
            check("wea", wea, m_wr);
            check("busy", busy, m_wr);
            check("done", done, (m_k == DEPTH + 1));
            check("expected_count", expected_count, m_exp);
            if (m_wr) begin
                check("addra", addra, m_k - 1);
                check("dina", dina, m_bits[m_k-1]);
            end
            if (reset) check("addra_in_reset", addra, 0);
        end
    end

    logic [DEPTH-1:0] got;
    int               done_cyc;
    int               ones2;

    task automatic run_fill(input logic m, input logic [7:0] s, input logic hold);
        got      = '0;
        done_cyc = -1;
        ones2    = 0;
        @(negedge clock_100Mhz);
        start = 1'b1;
        mode  = m;
        seed  = s;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock_100Mhz);
            if (c == 1 && !hold) start = 1'b0;
            if (c == 2) begin
                mode = ~m;
                seed = 8'h5A;
            end
            if (wea) got[addra] = dina;
            if (b_wea && b_dina) ones2++;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        check("done_cycle", done_cyc, DEPTH + 1);
        if (hold) begin
            @(negedge clock_100Mhz);
            start = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock_100Mhz);
        reset  = 1'b0;
        cmp_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_100Mhz);
            check("idle_wea", wea, 0);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_count", expected_count, 0);
        end

        // Repeated pattern; the second instance repeats 1111.
        run_fill(1'b1, 8'h00, 1'b0);
        check("m1_bits", got, 16'hDDDD);
        check("m1_count", expected_count, 4);
        check("p1111_ones", ones2, 16);
        check("p1111_count", b_expected_count, 4);

        run_fill(1'b0, 8'h80, 1'b0);
        check("s80_first", got[0], 1);
        check("s80_bits", got, gen_bits(1'b0, 8'h80));
        check("s80_count", expected_count, ref_count(gen_bits(1'b0, 8'h80)));

        run_fill(1'b0, 8'h00, 1'b0);
        check("s00_as_s01", got, gen_bits(1'b0, 8'h01));
`ifdef FORCE_PATTERN_EN
        check("s00_prefix", got[3:0], 4'hD);
        check("s00_count_ge1", (expected_count >= 8'd1), 1);
`else
        check("s00_first", got[0], 0);
        check("s00_low_byte", got[7:0], 8'h80);
`endif

        // Abort a fill with reset during its eighth write.
        @(negedge clock_100Mhz);
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clock_100Mhz);
        start = 1'b0;
        repeat (7) @(negedge clock_100Mhz);
        check("pre_abort_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_wea", wea, 0);
        check("abort_busy", busy, 0);
        check("abort_addra", addra, 0);
        check("abort_done", done, 0);
        @(negedge clock_100Mhz);
        reset = 1'b0;
        run_fill(1'b1, 8'h00, 1'b0);
        check("after_abort_count", expected_count, 4);

        // Start held through a whole fill and its done cycle.
        run_fill(1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock_100Mhz);
            check("held_start_idle_busy", busy, 0);
            check("held_start_no_done", done, 0);
        end
        check("held_start_count", expected_count, 4);

        repeat (2) @(negedge clock_100Mhz);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
